regfile_writer: RTL and testbench
=================================

# regfile_writer

Write side of the RV32I integer register file: holds the 32 architectural registers, accepts one write per cycle from the writeback stage over a valid/ready handshake, and drives all 32 register values in parallel to the read-port multiplexers. It also contains a clear sequencer that zeroes x1..x31 one register per cycle on request, for soft reset and debug. x0 is hardwired to zero.

## Interface
- XLEN, 32, data width of every register; only 32 is supported.
- NREG, 32, number of architectural registers; only 32 is supported.
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- wr_valid  input  1  writeback request valid.
- wr_addr  input  5  destination register index.
- wr_data  input  XLEN  write value.
- wr_ready  output  1  write accepted when high with wr_valid; equals (state == IDLE).
- clr_req  input  1  starts the clear sweep; sampled only in IDLE.
- clr_busy  output  1  high while the sweep runs.
- clr_done  output  1  single-cycle pulse after the last register is cleared.
- reg0 … reg31  output  XLEN each  current register contents; reg0 is constant 0.

## Operation
- Reset (async, on rst high): reg1..reg31 = 0; state = IDLE; idx = 1; clr_busy = 0; clr_done = 0; wr_ready = 1 once rst deasserts.
- States: IDLE and CLEAR.
- IDLE: if wr_valid, then at the edge reg[wr_addr] <= wr_data. A write with wr_addr = 0 is accepted and discarded. If clr_req, go to CLEAR at the same edge with idx <= 1.
- CLEAR: each edge does reg[idx] <= 0 and idx <= idx + 1. At idx = 31, clear reg31, go to IDLE, and set idx <= 1.
- During CLEAR, wr_ready = 0. wr_valid is ignored and no write occurs, so the producer must hold the request.
- clr_req is ignored while in CLEAR; requests are not queued.
- Simultaneous wr_valid and clr_req in IDLE: the write is performed at that edge, then the sweep starts. The written register therefore ends at 0.
- idx is a 5-bit counter that never takes the value 0 and wraps only through the explicit reload to 1.
- Write data is stored unmodified; there is no sign or width conversion.

## Timing
- Write latency: a write accepted at edge k is visible on regN immediately after edge k. There is no read-during-write bypass in this block.
- Clear: clr_req sampled at edge k makes clr_busy high from after edge k to after edge k+30. That is 31 cycles, with reg1..reg31 cleared at edges k+1..k+31 respectively.
- clr_done is high for exactly one cycle, the cycle after edge k+31. clr_busy is low in that cycle.
- wr_ready is combinational from state and is low in exactly the cycles clr_busy is high.
- clr_done and clr_busy are registered outputs.
- rst asserted mid-sweep:
  - all registers are zero immediately;
  - state = IDLE;
  - no clr_done pulse is produced.

## Structure
- Shared package regfile_pkg holds:
  - XLEN = 32, NREG = 32, REG_AW = 5;
  - the state enum {IDLE, CLEAR}.
  The read-side multiplexer uses the same constants.
- Sub-module regfile_clear_seq contains the FSM, idx counter, clr_busy and clr_done. It outputs clr_we and clr_idx.
- The top level holds the register array and the write-enable decode. The decode is a 5-to-32 one-hot, ORed with the clear enable, and bit 0 is forced to 0.

## Test plan
- Reset: assert rst asynchronously mid-cycle -> reg0..reg31 = 0 without waiting for a clock edge; wr_ready = 1, clr_busy = 0 and clr_done = 0 after release.
- Basic write: wr_valid=1, wr_addr=5, wr_data=0xDEADBEEF -> reg5 = 0xDEADBEEF after that edge and all other registers unchanged. Back-to-back writes x1=0x1, x31=0xFFFFFFFF on consecutive cycles both land.
- x0 write: wr_addr=0, wr_data=0x12345678 -> wr_ready=1, reg0 stays 0, no other register changes.
- Clear sweep: fill x1..x31 with 0xA5A5A5A5, pulse clr_req -> reg1..reg31 reach 0 in order over 31 edges, clr_busy high for 31 cycles, then a 1-cycle clr_done. While busy, hold wr_valid with wr_addr=7, wr_data=0x77 -> wr_ready=0 and reg7 stays 0 until IDLE, then reg7 = 0x77.
- Simultaneous write and clr_req: wr_addr=3, wr_data=0x33 with clr_req in the same cycle -> reg3 = 0x33 for 3 cycles, then 0. A second clr_req mid-sweep is ignored and clr_done pulses once.
- Reset mid-sweep: assert rst at sweep cycle 10 -> all registers 0, clr_busy falls, no clr_done; the first write after release is accepted normally.

Source files
------------

// File: rtl/regfile_pkg.sv
// ---------------------------------------------------------------------------
// regfile_pkg
// Shared constants and types for the RV32I integer register file (write side
// and read-side multiplexers).
//   XLEN   : register data width (32 only)
//   NREG   : number of architectural registers (32 only)
//   REG_AW : register index width
//   clr_state_t : clear sequencer states
// ---------------------------------------------------------------------------
package regfile_pkg;

  localparam int XLEN   = 32;
  localparam int NREG   = 32;
  localparam int REG_AW = 5;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } clr_state_t;

  // 5-to-32 one-hot decode of a register index.
  function automatic logic [NREG-1:0] reg_onehot(input logic [REG_AW-1:0] addr);
    reg_onehot = {{(NREG-1){1'b0}}, 1'b1} << addr;
  endfunction

endpackage

// File: rtl/regfile_clear_seq.sv
// ---------------------------------------------------------------------------
// regfile_clear_seq
// Clear sweep sequencer: on clr_req in IDLE, walks idx = 1..31 one register
// per cycle, asserting clr_we so the top level zeroes reg[idx].
// Ports:
//   clk, rst    : clock, asynchronous active-high reset
//   clr_req     : sweep request, sampled only in IDLE
//   seq_idle    : combinational (state == IDLE); becomes wr_ready at the top
//   clr_busy    : registered, high while the sweep runs
//   clr_done    : registered one-cycle pulse after reg31 is cleared
//   clr_we      : clear enable for reg[clr_idx] at the coming edge
//   clr_idx     : register being cleared (never 0)
// ---------------------------------------------------------------------------
module regfile_clear_seq
  import regfile_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_req,
  output logic              seq_idle,
  output logic              clr_busy,
  output logic              clr_done,
  output logic              clr_we,
  output logic [REG_AW-1:0] clr_idx
);

  clr_state_t        state_r;
  clr_state_t        state_s;
  logic [REG_AW-1:0] idx_r;
  logic [REG_AW-1:0] idx_s;
  logic              busy_r;
  logic              done_r;
  logic              done_s;

  // State, index counter and registered status flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      idx_r   <= 5'd1;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      idx_r   <= idx_s;
      busy_r  <= (state_s == CLEAR);
      done_r  <= done_s;
    end
  end

  // Next-state, next-index and done-pulse logic.
  always_comb begin
    state_s = state_r;
    idx_s   = idx_r;
    done_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (clr_req) begin
          state_s = CLEAR;
          idx_s   = 5'd1;
        end else begin
          state_s = IDLE;
        end
      end
      CLEAR: begin
        // idx only ever reloads to 1, so it never passes through 0.
        if (idx_r == 5'd31) begin
          state_s = IDLE;
          idx_s   = 5'd1;
          done_s  = 1'b1;
        end else begin
          idx_s   = idx_r + 5'd1;
        end
      end
      default: begin
        state_s = IDLE;
        idx_s   = 5'd1;
      end
    endcase
  end

  assign seq_idle = (state_r == IDLE);
  assign clr_we   = (state_r == CLEAR);
  assign clr_idx  = idx_r;
  assign clr_busy = busy_r;
  assign clr_done = done_r;

endmodule

// File: rtl/regfile_writer.sv
// ---------------------------------------------------------------------------
// regfile_writer
// Write side of the RV32I register file: 32 registers, one writeback write
// per cycle over valid/ready, a clear sweep for x1..x31, x0 hardwired to 0.
// Ports:
//   clk, rst          : clock, asynchronous active-high reset
//   wr_valid/wr_ready : writeback handshake (ready low during a clear sweep)
//   wr_addr, wr_data  : destination index and value
//   clr_req           : start clear sweep (IDLE only)
//   clr_busy/clr_done : sweep status (registered)
//   reg0..reg31       : register contents to the read multiplexers
// ---------------------------------------------------------------------------
module regfile_writer
  import regfile_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_valid,
  input  logic [REG_AW-1:0] wr_addr,
  input  logic [XLEN-1:0]   wr_data,
  output logic              wr_ready,
  input  logic              clr_req,
  output logic              clr_busy,
  output logic              clr_done,
  output logic [XLEN-1:0]   reg0,  output logic [XLEN-1:0] reg1,
  output logic [XLEN-1:0]   reg2,  output logic [XLEN-1:0] reg3,
  output logic [XLEN-1:0]   reg4,  output logic [XLEN-1:0] reg5,
  output logic [XLEN-1:0]   reg6,  output logic [XLEN-1:0] reg7,
  output logic [XLEN-1:0]   reg8,  output logic [XLEN-1:0] reg9,
  output logic [XLEN-1:0]   reg10, output logic [XLEN-1:0] reg11,
  output logic [XLEN-1:0]   reg12, output logic [XLEN-1:0] reg13,
  output logic [XLEN-1:0]   reg14, output logic [XLEN-1:0] reg15,
  output logic [XLEN-1:0]   reg16, output logic [XLEN-1:0] reg17,
  output logic [XLEN-1:0]   reg18, output logic [XLEN-1:0] reg19,
  output logic [XLEN-1:0]   reg20, output logic [XLEN-1:0] reg21,
  output logic [XLEN-1:0]   reg22, output logic [XLEN-1:0] reg23,
  output logic [XLEN-1:0]   reg24, output logic [XLEN-1:0] reg25,
  output logic [XLEN-1:0]   reg26, output logic [XLEN-1:0] reg27,
  output logic [XLEN-1:0]   reg28, output logic [XLEN-1:0] reg29,
  output logic [XLEN-1:0]   reg30, output logic [XLEN-1:0] reg31
);

  logic              seq_idle_s;
  logic              clr_we_s;
  logic [REG_AW-1:0] clr_idx_s;
  logic              wr_fire_s;
  logic [NREG-1:0]   we_s;
  logic [XLEN-1:0]   reg_r [NREG];

  regfile_clear_seq u_clear_seq (
    .clk      (clk),
    .rst      (rst),
    .clr_req  (clr_req),
    .seq_idle (seq_idle_s),
    .clr_busy (clr_busy),
    .clr_done (clr_done),
    .clr_we   (clr_we_s),
    .clr_idx  (clr_idx_s)
  );

  assign wr_ready  = seq_idle_s;
  assign wr_fire_s = wr_valid & seq_idle_s;

  // Write-enable decode: writeback one-hot ORed with clear one-hot, x0 never enabled.
  always_comb begin
    we_s    = (wr_fire_s ? reg_onehot(wr_addr)   : {NREG{1'b0}})
            | (clr_we_s  ? reg_onehot(clr_idx_s) : {NREG{1'b0}});
    we_s[0] = 1'b0;
  end

  // Register array; writes and clears are exclusive because writes need IDLE.
  // reg_r[0] has no enable, so it holds its reset value of zero forever.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        reg_r[i] <= {XLEN{1'b0}};
      end
    end else begin
      for (int i = 0; i < NREG; i++) begin
        if (we_s[i]) begin
          reg_r[i] <= clr_we_s ? {XLEN{1'b0}} : wr_data;
        end
      end
    end
  end

  assign reg0  = reg_r[0];  assign reg1  = reg_r[1];
  assign reg2  = reg_r[2];  assign reg3  = reg_r[3];
  assign reg4  = reg_r[4];  assign reg5  = reg_r[5];
  assign reg6  = reg_r[6];  assign reg7  = reg_r[7];
  assign reg8  = reg_r[8];  assign reg9  = reg_r[9];
  assign reg10 = reg_r[10]; assign reg11 = reg_r[11];
  assign reg12 = reg_r[12]; assign reg13 = reg_r[13];
  assign reg14 = reg_r[14]; assign reg15 = reg_r[15];
  assign reg16 = reg_r[16]; assign reg17 = reg_r[17];
  assign reg18 = reg_r[18]; assign reg19 = reg_r[19];
  assign reg20 = reg_r[20]; assign reg21 = reg_r[21];
  assign reg22 = reg_r[22]; assign reg23 = reg_r[23];
  assign reg24 = reg_r[24]; assign reg25 = reg_r[25];
  assign reg26 = reg_r[26]; assign reg27 = reg_r[27];
  assign reg28 = reg_r[28]; assign reg29 = reg_r[29];
  assign reg30 = reg_r[30]; assign reg31 = reg_r[31];

endmodule

// File: tb/tb_regfile_writer.sv
// ---------------------------------------------------------------------------
// tb_regfile_writer
// Directed and random stimulus for regfile_writer, checked against a
// behavioural model of the register file contents and sweep progress.
// ---------------------------------------------------------------------------
module tb_regfile_writer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_valid = 1'b0;
  logic [4:0]  wr_addr = 5'd0;
  logic [31:0] wr_data = 32'd0;
  logic        wr_ready;
  logic        clr_req = 1'b0;
  logic        clr_busy;
  logic        clr_done;
  logic [31:0] reg0, reg1, reg2, reg3, reg4, reg5, reg6, reg7,
               reg8, reg9, reg10, reg11, reg12, reg13, reg14, reg15,
               reg16, reg17, reg18, reg19, reg20, reg21, reg22, reg23,
               reg24, reg25, reg26, reg27, reg28, reg29, reg30, reg31;
  logic [31:0] dut_regs [32];

  int checks = 0;
  int errors = 0;

  // Reference model
  logic [31:0] model [32];
  int          sweep_left;
  int          sweep_next;
  logic        exp_done;
  int          busy_cycles;
  int          done_pulses;

  always #5 clk = ~clk;

  regfile_writer dut (
    .clk(clk), .rst(rst),
    .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
    .clr_req(clr_req), .clr_busy(clr_busy), .clr_done(clr_done),
    .reg0(reg0),   .reg1(reg1),   .reg2(reg2),   .reg3(reg3),
    .reg4(reg4),   .reg5(reg5),   .reg6(reg6),   .reg7(reg7),
    .reg8(reg8),   .reg9(reg9),   .reg10(reg10), .reg11(reg11),
    .reg12(reg12), .reg13(reg13), .reg14(reg14), .reg15(reg15),
    .reg16(reg16), .reg17(reg17), .reg18(reg18), .reg19(reg19),
    .reg20(reg20), .reg21(reg21), .reg22(reg22), .reg23(reg23),
    .reg24(reg24), .reg25(reg25), .reg26(reg26), .reg27(reg27),
    .reg28(reg28), .reg29(reg29), .reg30(reg30), .reg31(reg31)
  );

  assign dut_regs[0]  = reg0;  assign dut_regs[1]  = reg1;
  assign dut_regs[2]  = reg2;  assign dut_regs[3]  = reg3;
  assign dut_regs[4]  = reg4;  assign dut_regs[5]  = reg5;
  assign dut_regs[6]  = reg6;  assign dut_regs[7]  = reg7;
  assign dut_regs[8]  = reg8;  assign dut_regs[9]  = reg9;
  assign dut_regs[10] = reg10; assign dut_regs[11] = reg11;
  assign dut_regs[12] = reg12; assign dut_regs[13] = reg13;
  assign dut_regs[14] = reg14; assign dut_regs[15] = reg15;
  assign dut_regs[16] = reg16; assign dut_regs[17] = reg17;
  assign dut_regs[18] = reg18; assign dut_regs[19] = reg19;
  assign dut_regs[20] = reg20; assign dut_regs[21] = reg21;
  assign dut_regs[22] = reg22; assign dut_regs[23] = reg23;
  assign dut_regs[24] = reg24; assign dut_regs[25] = reg25;
  assign dut_regs[26] = reg26; assign dut_regs[27] = reg27;
  assign dut_regs[28] = reg28; assign dut_regs[29] = reg29;
  assign dut_regs[30] = reg30; assign dut_regs[31] = reg31;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic reset_model();
    for (int i = 0; i < 32; i++) model[i] = 32'd0;
    sweep_left = 0;
    sweep_next = 1;
    exp_done   = 1'b0;
  endtask

  // What the coming clock edge does, in terms of register contents.
  task automatic model_edge();
    if (sweep_left == 0) begin
      if (wr_valid && wr_addr != 5'd0) model[wr_addr] = wr_data;
      if (clr_req) begin
        sweep_left = 31;
        sweep_next = 1;
      end
      exp_done = 1'b0;
    end else begin
      model[sweep_next] = 32'd0;
      sweep_next++;
      sweep_left--;
      exp_done = (sweep_left == 0);
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < 32; i++) chk($sformatf("reg%0d", i), dut_regs[i], model[i]);
    chk("wr_ready", {31'd0, wr_ready}, {31'd0, (sweep_left == 0)});
    chk("clr_busy", {31'd0, clr_busy}, {31'd0, (sweep_left != 0)});
    chk("clr_done", {31'd0, clr_done}, {31'd0, exp_done});
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    if (clr_busy) busy_cycles++;
    if (clr_done) done_pulses++;
    check_all();
  endtask

  task automatic idle_inputs();
    wr_valid = 1'b0;
    wr_addr  = 5'd0;
    wr_data  = 32'd0;
    clr_req  = 1'b0;
  endtask

  task automatic write(input logic [4:0] a, input logic [31:0] d);
    wr_valid = 1'b1;
    wr_addr  = a;
    wr_data  = d;
    step();
    idle_inputs();
  endtask

  initial begin
    int saved_done;
    reset_model();
    busy_cycles = 0;
    done_pulses = 0;

    // Power-on reset, released away from a clock edge
    #12;
    rst = 1'b0;
    #1;
    check_all();
    @(posedge clk); #1;

    // Fill a few registers, then reset asynchronously mid-cycle
    write(5'd2, 32'h1111_2222);
    write(5'd9, 32'h9999_0000);
    #3;
    rst = 1'b1;
    #1;
    reset_model();
    check_all();
    #2;
    rst = 1'b0;
    #1;
    check_all();
    @(posedge clk); #1;

    // Basic write and back-to-back writes
    write(5'd5, 32'hDEAD_BEEF);
    wr_valid = 1'b1; wr_addr = 5'd1;  wr_data = 32'h0000_0001; step();
    wr_valid = 1'b1; wr_addr = 5'd31; wr_data = 32'hFFFF_FFFF; step();
    idle_inputs();
    chk("b2b_x1", reg1, 32'h0000_0001);
    chk("b2b_x31", reg31, 32'hFFFF_FFFF);

    // x0 write is accepted and discarded
    wr_valid = 1'b1; wr_addr = 5'd0; wr_data = 32'h1234_5678;
    chk("x0_ready", {31'd0, wr_ready}, 32'd1);
    step();
    idle_inputs();
    chk("x0_zero", reg0, 32'd0);

    // Clear sweep with a write held pending throughout
    for (int i = 1; i < 32; i++) write(i[4:0], 32'hA5A5_A5A5);
    busy_cycles = 0;
    done_pulses = 0;
    clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    wr_valid = 1'b1; wr_addr = 5'd7; wr_data = 32'h0000_0077;
    for (int i = 0; i < 33; i++) step();
    idle_inputs();
    chk("sweep_busy_cycles", busy_cycles, 32'd31);
    chk("sweep_done_pulses", done_pulses, 32'd1);
    chk("held_write_x7", reg7, 32'h0000_0077);

    // Simultaneous write and clr_req, with a second clr_req mid-sweep
    busy_cycles = 0;
    done_pulses = 0;
    wr_valid = 1'b1; wr_addr = 5'd3; wr_data = 32'h0000_0033; clr_req = 1'b1;
    step();
    idle_inputs();
    chk("simul_x3_written", reg3, 32'h0000_0033);
    for (int i = 0; i < 34; i++) begin
      clr_req = (i == 10);
      step();
    end
    idle_inputs();
    chk("simul_x3_cleared", reg3, 32'd0);
    chk("simul_busy_cycles", busy_cycles, 32'd31);
    chk("simul_done_pulses", done_pulses, 32'd1);

    // Reset mid-sweep
    for (int i = 1; i < 32; i++) write(i[4:0], 32'h5A5A_0000 | i);
    clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    for (int i = 0; i < 9; i++) step();
    saved_done = done_pulses;
    #2;
    rst = 1'b1;
    #1;
    reset_model();
    check_all();
    #2;
    rst = 1'b0;
    for (int i = 0; i < 40; i++) step();
    chk("rst_no_done", done_pulses, saved_done);
    write(5'd9, 32'hCAFE_F00D);
    chk("post_rst_write", reg9, 32'hCAFE_F00D);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      wr_valid = ($urandom_range(0, 1) == 1);
      wr_addr  = 5'($urandom_range(0, 31));
      wr_data  = $urandom();
      clr_req  = ($urandom_range(0, 39) == 0);
      step();
    end
    idle_inputs();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
